// File: rtl/inst_fetch_bridge.sv
// inst_fetch_bridge: one-line instruction buffer that serves hits combinationally and refills by burst on a miss
module inst_fetch_bridge #(
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        ce,
  input  logic        flush,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        stall_req,
  output logic        fetch_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam int OFF = $clog2(LINE_WORDS);
  localparam int TW = 30 - OFF;
  localparam logic [OFF-1:0] LAST = OFF'(LINE_WORDS - 1);
  typedef enum logic {IDLE, FILL} state_t;
  state_t state;
  logic [TW-1:0] tag, pend_tag, pc_tag;
  logic [OFF-1:0] beat, pc_word;
  logic line_valid, drop, aligned, hit;
  logic [31:0] line_buf [LINE_WORDS];
  // Address split and hit/stall decode; the buffer is never read while a refill is in flight
  always_comb begin
    pc_tag = pc[31:OFF+2];
    pc_word = pc[OFF+1:2];
    aligned = pc[1:0] == 2'b00;
    hit = line_valid && tag == pc_tag && state == IDLE;
    inst_valid = ce && aligned && hit;
    stall_req = ce && aligned && !hit;
    inst = inst_valid ? line_buf[pc_word] : 32'd0;
  end
  // Refill FSM: start a burst on an aligned miss, capture beats in ack order, validate the line at the last beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      tag <= '0;
      pend_tag <= '0;
      line_valid <= 1'b0;
      beat <= '0;
      drop <= 1'b0;
      mem_req <= 1'b0;
      mem_addr <= '0;
      fetch_err <= 1'b0;
      for (int i = 0; i < LINE_WORDS; i++) line_buf[i] <= '0;
    end else begin
      fetch_err <= ce && !aligned;
      if (state == IDLE) begin
        if (flush) begin
          line_valid <= 1'b0;
        end else if (ce && aligned && !hit) begin
          mem_req <= 1'b1;
          mem_addr <= {pc_tag, {(OFF+2){1'b0}}};
          beat <= '0;
          pend_tag <= pc_tag;
          line_valid <= 1'b0;
          drop <= 1'b0;
          state <= FILL;
        end
      end else begin
        if (flush) drop <= 1'b1;
        if (mem_ack) begin
          line_buf[beat] <= mem_rdata;
          beat <= beat + OFF'(1);
          mem_addr <= mem_addr + 32'd4;
          if (beat == LAST) begin
            mem_req <= 1'b0;
            state <= IDLE;
            tag <= pend_tag;
            line_valid <= !drop && !flush;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch_bridge.sv
// tb_inst_fetch_bridge: directed scoreboard bench for the fetch line buffer
module tb_inst_fetch_bridge;
  localparam int LW = 4;
  logic clk, rst, ce, flush, mem_ack;
  logic [31:0] pc, mem_rdata, inst, mem_addr;
  logic inst_valid, stall_req, fetch_err, mem_req;
  logic [31:0] exp_addr [$];
  logic [31:0] exp_data [$];
  int vectors = 0;
  int errors = 0;
  int st;

  inst_fetch_bridge #(.LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst), .pc(pc), .ce(ce), .flush(flush),
    .inst(inst), .inst_valid(inst_valid), .stall_req(stall_req), .fetch_err(fetch_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one burst starting at the current negedge (cycle 0 = miss cycle); ap bit n is the ack for the n-th requested cycle
  task automatic run_fill(input logic [31:0] base, input logic [31:0] dbase, input logic [15:0] ap,
                          input int flush_beat, output int stalls);
    int k, p;
    k = 0;
    p = 0;
    stalls = 0;
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < LW; i++) exp_addr.push_back(base + 32'(4 * i));
    for (int c = 0; c < 64 && k < LW; c++) begin
      mem_ack = mem_req ? (p < 16 ? ap[p] : 1'b1) : 1'b0;
      if (mem_req) p++;
      mem_rdata = dbase + 32'(k);
      flush = mem_req && k == flush_beat;
      #1;
      if (stall_req) stalls++;
      if (mem_req && exp_addr.size() > 0) begin
        chk("mem_addr", mem_addr, exp_addr[0]);
        if (mem_ack) begin
          void'(exp_addr.pop_front());
          exp_data.push_back(dbase + 32'(k));
          k++;
        end
      end
      @(negedge clk);
    end
    mem_ack = 0;
    flush = 0;
    #1;
    chk("fill_beats", 32'(k), 32'(LW));
    chk("fill_mem_req_low", 32'(mem_req), 32'd0);
  endtask

  initial begin
    rst = 0; ce = 1; pc = 0; flush = 0; mem_ack = 0; mem_rdata = 0;
    #2;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_stall_req", 32'(stall_req), 32'd1);
    chk("rst_fetch_err", 32'(fetch_err), 32'd0);
    @(negedge clk);
    rst = 1;
    run_fill(32'h0, 32'h1000, 16'hFFFF, -1, st);
    chk("fill1_stalls", 32'(st), 32'd5);
    chk("fill1_valid", 32'(inst_valid), 32'd1);
    chk("fill1_inst", inst, exp_data.pop_front());
    chk("fill1_stall_off", 32'(stall_req), 32'd0);
    @(negedge clk);
    for (int i = 1; i < LW; i++) begin
      pc = 32'(4 * i);
      mem_ack = 1;
      #1;
      chk("hit_inst", inst, exp_data.pop_front());
      chk("hit_valid", 32'(inst_valid), 32'd1);
      chk("hit_stall", 32'(stall_req), 32'd0);
      chk("hit_mem_req", 32'(mem_req), 32'd0);
      @(negedge clk);
    end
    mem_ack = 0;
    pc = 32'h10;
    run_fill(32'h10, 32'h2000, 16'hFFF9, -1, st);
    chk("fill2_stalls", 32'(st), 32'd7);
    for (int i = 0; i < LW; i++) begin
      pc = 32'h10 + 32'(4 * i);
      #1;
      chk("fill2_inst", inst, exp_data.pop_front());
      chk("fill2_valid", 32'(inst_valid), 32'd1);
      @(negedge clk);
    end
    pc = 32'h20;
    run_fill(32'h20, 32'h3000, 16'hFFFF, 1, st);
    chk("flush_fill_stalls", 32'(st), 32'd5);
    chk("flush_line_invalid", 32'(inst_valid), 32'd0);
    chk("flush_inst_zero", inst, 32'd0);
    chk("flush_stall", 32'(stall_req), 32'd1);
    run_fill(32'h20, 32'h4000, 16'hFFFF, -1, st);
    chk("refill_stalls", 32'(st), 32'd5);
    chk("refill_inst", inst, exp_data.pop_front());
    @(negedge clk);
    pc = 32'h6;
    #1;
    chk("mis_inst", inst, 32'd0);
    chk("mis_valid", 32'(inst_valid), 32'd0);
    chk("mis_stall", 32'(stall_req), 32'd0);
    chk("mis_mem_req", 32'(mem_req), 32'd0);
    chk("mis_err_same_cycle", 32'(fetch_err), 32'd0);
    @(negedge clk);
    pc = 32'h20;
    #1;
    chk("mis_err_pulse", 32'(fetch_err), 32'd1);
    chk("mis_no_req", 32'(mem_req), 32'd0);
    chk("mis_then_hit", inst, 32'h4000);
    @(negedge clk);
    #1;
    chk("mis_err_clear", 32'(fetch_err), 32'd0);
    @(negedge clk);
    pc = 32'h40;
    mem_ack = 1;
    mem_rdata = 32'h5555;
    for (int i = 0; i < 3; i++) @(negedge clk);
    #1;
    chk("abort_pre_req", 32'(mem_req), 32'd1);
    chk("abort_pre_addr", mem_addr, 32'h48);
    rst = 0;
    #1;
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    chk("abort_stall", 32'(stall_req), 32'd1);
    chk("abort_valid", 32'(inst_valid), 32'd0);
    chk("abort_fetch_err", 32'(fetch_err), 32'd0);
    @(negedge clk);
    rst = 1;
    run_fill(32'h40, 32'h6000, 16'hFFFF, -1, st);
    chk("restart_stalls", 32'(st), 32'd5);
    chk("restart_inst", inst, exp_data.pop_front());
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
